// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter serializing single-beat MMIO transactions
// onto the shared FPro bus, returning read data and a one-cycle ack.
module mmio_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data,
    output logic              grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t            state;
    logic              ptr;
    logic              start;
    logic              winner;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wr_data;

    // In ACK only the master not just served may be granted, so back-to-back
    // alternation costs no IDLE cycle while a lone master always passes IDLE.
    always_comb begin
        start  = 1'b0;
        winner = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    start  = 1'b1;
                    winner = ptr;
                end else if (m0_req || m1_req) begin
                    start  = 1'b1;
                    winner = m1_req;
                end
            end
            ACK: begin
                winner = ~grant;
                start  = grant ? m0_req : m1_req;
            end
            default: begin
                start  = 1'b0;
                winner = 1'b0;
            end
        endcase
    end

    assign sel_wr      = winner ? m1_wr      : m0_wr;
    assign sel_addr    = winner ? m1_addr    : m0_addr;
    assign sel_wr_data = winner ? m1_wr_data : m0_wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            grant        <= 1'b0;
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_rd      <= 1'b0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rd_data   <= '0;
            m1_rd_data   <= '0;
        end else begin
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            mmio_cs <= 1'b0;
            mmio_wr <= 1'b0;
            mmio_rd <= 1'b0;
            case (state)
                IDLE, ACK: begin
                    if (start) begin
                        state        <= ISSUE;
                        mmio_cs      <= 1'b1;
                        mmio_wr      <= sel_wr;
                        mmio_rd      <= ~sel_wr;
                        mmio_addr    <= sel_addr;
                        mmio_wr_data <= sel_wr_data;
                        grant        <= winner;
                        ptr          <= ~winner;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (mmio_rd) begin
                        if (grant) m1_rd_data <= mmio_rd_data;
                        else       m0_rd_data <= mmio_rd_data;
                    end
                    if (grant) m1_ack <= 1'b1;
                    else       m0_ack <= 1'b1;
                    state <= ACK;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed self-checking bench for mmio_bus_arbiter: reset, single read/write,
// simultaneous requests, continuous contention, held request and mid-cycle reset.
module tb_mmio_bus_arbiter;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              m0_req, m0_wr, m0_ack;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wr_data, m0_rd_data;
    logic              m1_req, m1_wr, m1_ack;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wr_data, m1_rd_data;
    logic              mmio_cs, mmio_wr, mmio_rd, grant;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data, mmio_rd_data;
    logic [DATA_W-1:0] bus_rd_value;

    int checks = 0;
    int passes = 0;

    mmio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_data(mmio_rd_data), .grant(grant)
    );

    // Bus slave model: returns data whenever selected, so a capture on a write would be visible.
    assign mmio_rd_data = mmio_cs ? bus_rd_value : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b000) $display("[TB] FAIL reset_strobes: got %b expected 000", {mmio_cs, mmio_wr, mmio_rd}); else passes++;
        checks++; if ({m0_ack, m1_ack, grant} !== 3'b000) $display("[TB] FAIL reset_acks_grant: got %b expected 000", {m0_ack, m1_ack, grant}); else passes++;
        checks++; if ({mmio_addr, mmio_wr_data} !== '0) $display("[TB] FAIL reset_bus_regs: got %h/%h expected 0/0", mmio_addr, mmio_wr_data); else passes++;
        checks++; if ({m0_rd_data, m1_rd_data} !== '0) $display("[TB] FAIL reset_rd_data: got %h/%h expected 0/0", m0_rd_data, m1_rd_data); else passes++;
    endtask

    task automatic test_single_read();
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h000C0; bus_rd_value = 32'hDEADBEEF;
        step();
        checks++; if ({mmio_cs, mmio_rd, mmio_wr} !== 3'b110) $display("[TB] FAIL read_strobe: got %b expected 110", {mmio_cs, mmio_rd, mmio_wr}); else passes++;
        checks++; if (mmio_addr !== 21'h000C0) $display("[TB] FAIL read_addr: got %h expected 000c0", mmio_addr); else passes++;
        checks++; if ({grant, m0_ack} !== 2'b00) $display("[TB] FAIL read_grant_early_ack: got %b expected 00", {grant, m0_ack}); else passes++;
        step();
        bus_rd_value = 32'h0;
        checks++; if ({m0_ack, m1_ack, mmio_cs, mmio_rd} !== 4'b1000) $display("[TB] FAIL read_ack: got %b expected 1000", {m0_ack, m1_ack, mmio_cs, mmio_rd}); else passes++;
        checks++; if (m0_rd_data !== 32'hDEADBEEF) $display("[TB] FAIL read_data: got %h expected deadbeef", m0_rd_data); else passes++;
        m0_req = 1'b0;
        step();
        checks++; if ({m0_ack, mmio_cs} !== 2'b00) $display("[TB] FAIL read_idle: got %b expected 00", {m0_ack, mmio_cs}); else passes++;
        checks++; if (m0_rd_data !== 32'hDEADBEEF) $display("[TB] FAIL read_data_hold: got %h expected deadbeef", m0_rd_data); else passes++;
    endtask

    task automatic test_single_write();
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 21'h00180; m1_wr_data = 32'h000003FF; bus_rd_value = 32'h12345678;
        step();
        checks++; if ({mmio_cs, mmio_wr, mmio_rd, grant} !== 4'b1101) $display("[TB] FAIL write_strobe: got %b expected 1101", {mmio_cs, mmio_wr, mmio_rd, grant}); else passes++;
        checks++; if (mmio_addr !== 21'h00180 || mmio_wr_data !== 32'h3FF) $display("[TB] FAIL write_bus: got %h/%h expected 00180/000003ff", mmio_addr, mmio_wr_data); else passes++;
        step();
        checks++; if ({m1_ack, m0_ack, mmio_wr} !== 3'b100) $display("[TB] FAIL write_ack: got %b expected 100", {m1_ack, m0_ack, mmio_wr}); else passes++;
        checks++; if (m1_rd_data !== 32'h0 || m0_rd_data !== 32'hDEADBEEF) $display("[TB] FAIL write_rd_data_kept: got %h/%h expected 0/deadbeef", m1_rd_data, m0_rd_data); else passes++;
        checks++; if (mmio_addr !== 21'h00180) $display("[TB] FAIL write_addr_hold: got %h expected 00180", mmio_addr); else passes++;
        m1_req = 1'b0;
        step();
        checks++; if (m1_ack !== 1'b0) $display("[TB] FAIL write_ack_pulse: got %b expected 0", m1_ack); else passes++;
    endtask

    task automatic test_simultaneous();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00010;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00020;
        step();
        checks++; if ({mmio_rd, grant} !== 2'b10 || mmio_addr !== 21'h00010) $display("[TB] FAIL simul_first: got rd/grant %b addr %h expected 10 00010", {mmio_rd, grant}, mmio_addr); else passes++;
        bus_rd_value = 32'h11110000;
        step();
        checks++; if ({m0_ack, m1_ack} !== 2'b10 || m0_rd_data !== 32'h11110000) $display("[TB] FAIL simul_ack0: got %b %h expected 10 11110000", {m0_ack, m1_ack}, m0_rd_data); else passes++;
        m0_req = 1'b0; bus_rd_value = 32'h22220000;
        step();
        checks++; if ({mmio_cs, mmio_rd, grant, m0_ack, m1_ack} !== 5'b11100 || mmio_addr !== 21'h00020) $display("[TB] FAIL simul_second: got %b addr %h expected 11100 00020", {mmio_cs, mmio_rd, grant, m0_ack, m1_ack}, mmio_addr); else passes++;
        step();
        checks++; if ({m0_ack, m1_ack} !== 2'b01 || m1_rd_data !== 32'h22220000) $display("[TB] FAIL simul_ack1: got %b %h expected 01 22220000", {m0_ack, m1_ack}, m1_rd_data); else passes++;
        m1_req = 1'b0;
        step();
    endtask

    task automatic test_contention();
        logic exp_grant = 1'b0;
        logic last_grant = 1'b0;
        logic prev_cs = 1'b0;
        int issues = 0;
        int acks = 0;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h00100; m0_wr_data = 32'h0000000A;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 21'h00200; m1_wr_data = 32'h0000000B;
        for (int cyc = 0; cyc < 40 && acks < 10; cyc++) begin
            step();
            checks++; if (mmio_wr && mmio_rd) $display("[TB] FAIL cont_strobe_overlap: got wr=%b rd=%b expected not both", mmio_wr, mmio_rd); else passes++;
            checks++; if (m0_ack && m1_ack) $display("[TB] FAIL cont_dual_ack: got %b%b expected not both", m0_ack, m1_ack); else passes++;
            if (mmio_cs) begin
                checks++; if (grant !== exp_grant) $display("[TB] FAIL cont_grant_order: got %b expected %b", grant, exp_grant); else passes++;
                checks++; if (mmio_wr_data !== (exp_grant ? 32'hB : 32'hA)) $display("[TB] FAIL cont_wr_data: got %h expected %h", mmio_wr_data, exp_grant ? 32'hB : 32'hA); else passes++;
                last_grant = grant;
                exp_grant  = ~exp_grant;
                issues++;
                if (issues == 10) begin
                    if (grant) m0_req = 1'b0;
                    else       m1_req = 1'b0;
                end
            end
            if (m0_ack || m1_ack) begin
                checks++; if (!prev_cs || m1_ack !== last_grant) $display("[TB] FAIL cont_ack_follow: got prev_cs=%b m1_ack=%b expected 1 %b", prev_cs, m1_ack, last_grant); else passes++;
                acks++;
                if (acks == 10) begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
            end
            prev_cs = mmio_cs;
        end
        checks++; if (acks != 10 || issues != 10) $display("[TB] FAIL cont_count: got %0d issues %0d acks expected 10 10", issues, acks); else passes++;
        step();
        checks++; if ({mmio_cs, m0_ack, m1_ack} !== 3'b000) $display("[TB] FAIL cont_idle: got %b expected 000", {mmio_cs, m0_ack, m1_ack}); else passes++;
    endtask

    task automatic test_held_req();
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00040; bus_rd_value = 32'h5A5A5A5A;
        step();
        checks++; if ({mmio_cs, mmio_rd, grant} !== 3'b110) $display("[TB] FAIL held_issue1: got %b expected 110", {mmio_cs, mmio_rd, grant}); else passes++;
        step();
        checks++; if (m0_ack !== 1'b1 || m0_rd_data !== 32'h5A5A5A5A) $display("[TB] FAIL held_ack1: got %b %h expected 1 5a5a5a5a", m0_ack, m0_rd_data); else passes++;
        step();
        checks++; if ({mmio_cs, m0_ack} !== 2'b00) $display("[TB] FAIL held_no_reissue: got %b expected 00", {mmio_cs, m0_ack}); else passes++;
        step();
        checks++; if ({mmio_cs, mmio_rd, grant} !== 3'b110) $display("[TB] FAIL held_issue2: got %b expected 110", {mmio_cs, mmio_rd, grant}); else passes++;
        step();
        checks++; if (m0_ack !== 1'b1) $display("[TB] FAIL held_ack2: got %b expected 1", m0_ack); else passes++;
        m0_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00080; bus_rd_value = 32'h77770000;
        step();
        checks++; if ({mmio_cs, mmio_rd, grant} !== 3'b111) $display("[TB] FAIL rst_pre_issue: got %b expected 111", {mmio_cs, mmio_rd, grant}); else passes++;
        reset = 1'b1;
        #1;
        checks++; if ({mmio_cs, mmio_wr, mmio_rd, m0_ack, m1_ack} !== 5'b00000) $display("[TB] FAIL rst_issue_async: got %b expected 00000", {mmio_cs, mmio_wr, mmio_rd, m0_ack, m1_ack}); else passes++;
        checks++; if (m0_rd_data !== 32'h0 || grant !== 1'b0) $display("[TB] FAIL rst_issue_regs: got %h %b expected 0 0", m0_rd_data, grant); else passes++;
        step();
        checks++; if (m1_ack !== 1'b0) $display("[TB] FAIL rst_no_ack: got %b expected 0", m1_ack); else passes++;
        reset = 1'b0;
        step();
        checks++; if ({mmio_cs, mmio_rd, grant, m1_ack} !== 4'b1110) $display("[TB] FAIL rst_reissue: got %b expected 1110", {mmio_cs, mmio_rd, grant, m1_ack}); else passes++;
        step();
        checks++; if (m1_ack !== 1'b1 || m1_rd_data !== 32'h77770000) $display("[TB] FAIL rst_served: got %b %h expected 1 77770000", m1_ack, m1_rd_data); else passes++;
        reset = 1'b1;
        m1_req = 1'b0;
        #1;
        checks++; if (m1_ack !== 1'b0 || m1_rd_data !== 32'h0) $display("[TB] FAIL rst_ack_async: got %b %h expected 0 0", m1_ack, m1_rd_data); else passes++;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wr_data = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wr_data = '0;
        bus_rd_value = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_single_read();
        test_single_write();
        test_simultaneous();
        test_contention();
        test_held_req();
        test_reset_mid();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
